// File: rtl/l2_sim_pkg.sv
// Shared trace/cache types: L2 operation codes, command legality and L1-access helpers.
package l2_sim_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [3:0] {
    OP_DREAD     = 4'd0,
    OP_DWRITE    = 4'd1,
    OP_IREAD     = 4'd2,
    OP_SNP_INV   = 4'd3,
    OP_SNP_READ  = 4'd4,
    OP_SNP_WRITE = 4'd5,
    OP_SNP_RWIM  = 4'd6,
    OP_CLEAR     = 4'd8,
    OP_PRINT     = 4'd9
  } l2_op_t;

  function automatic logic cmd_legal(input logic [3:0] code);
    return (code <= 4'd6) || (code == 4'd8) || (code == 4'd9);
  endfunction

  // Only processor-side accesses contribute to hit/miss statistics.
  function automatic logic is_l1_access(input l2_op_t op);
    return (op == OP_DREAD) || (op == OP_DWRITE) || (op == OP_IREAD);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/trace_dispatcher.sv
// Trace record to L2 request sequencer, one op in flight, with response watchdog.
// Statistics counters are built only when DISPATCH_STATS_EN is defined.
//
// state     | meaning
// IDLE      | ready for a trace record
// ISSUE     | request held on req_* until the cache accepts it
// WAIT_RESP | waiting for resp_valid, watchdog counting down
module trace_dispatcher
  import l2_sim_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_valid,
  output logic              trace_ready,
  input  logic [3:0]        trace_cmd,
  input  logic [ADDR_W-1:0] trace_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [3:0]        req_op,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic              resp_hit,
  output logic              busy,
  output logic              cmd_err,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stat_reads,
  output logic [CNT_W-1:0]  stat_writes,
  output logic [CNT_W-1:0]  stat_ifetch,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RESP} state_t;

  state_t            state_d, state_q;
  l2_op_t            op_d, op_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [WD_W-1:0]   wd_d, wd_q;
  logic              cmd_err_d, cmd_err_q;
  logic              to_err_d, to_err_q;
  logic              trace_ready_d, trace_ready_q;
  logic              req_valid_d, req_valid_q;
  logic              busy_d, busy_q;
  logic              stat_clr, stat_done;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    cmd_err_d = cmd_err_q;
    to_err_d  = to_err_q;
    stat_clr  = 1'b0;
    stat_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trace_valid) begin
          if (cmd_legal(trace_cmd)) begin
            op_d     = l2_op_t'(trace_cmd);
            addr_d   = (op_d == OP_CLEAR || op_d == OP_PRINT) ? '0 : trace_addr;
            stat_clr = (op_d == OP_CLEAR);
            state_d  = ST_ISSUE;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          wd_d    = WD_W'(TIMEOUT - 1);
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        // A response arriving on the expiry cycle is still accepted.
        if (resp_valid) begin
          stat_done = 1'b1;
          state_d   = ST_IDLE;
        end else if (wd_q == '0) begin
          to_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    trace_ready_d = (state_d == ST_IDLE);
    req_valid_d   = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_DREAD;
      addr_q        <= '0;
      wd_q          <= '0;
      cmd_err_q     <= 1'b0;
      to_err_q      <= 1'b0;
      trace_ready_q <= 1'b1;
      req_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wd_q          <= wd_d;
      cmd_err_q     <= cmd_err_d;
      to_err_q      <= to_err_d;
      trace_ready_q <= trace_ready_d;
      req_valid_q   <= req_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign trace_ready = trace_ready_q;
  assign req_valid   = req_valid_q;
  assign req_op      = op_q;
  assign req_addr    = addr_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;
  assign timeout_err = to_err_q;

`ifdef DISPATCH_STATS_EN
  logic l1_done;
  assign l1_done = stat_done && is_l1_access(op_q);

  sat_counter #(.W(CNT_W)) u_reads (
    .clk(clk), .rst_n(reset_n), .inc(stat_done && op_q == OP_DREAD),
    .clr(stat_clr), .q(stat_reads)
  );
  sat_counter #(.W(CNT_W)) u_writes (
    .clk(clk), .rst_n(reset_n), .inc(stat_done && op_q == OP_DWRITE),
    .clr(stat_clr), .q(stat_writes)
  );
  sat_counter #(.W(CNT_W)) u_ifetch (
    .clk(clk), .rst_n(reset_n), .inc(stat_done && op_q == OP_IREAD),
    .clr(stat_clr), .q(stat_ifetch)
  );
  sat_counter #(.W(CNT_W)) u_hits (
    .clk(clk), .rst_n(reset_n), .inc(l1_done && resp_hit),
    .clr(stat_clr), .q(stat_hits)
  );
  sat_counter #(.W(CNT_W)) u_misses (
    .clk(clk), .rst_n(reset_n), .inc(l1_done && !resp_hit),
    .clr(stat_clr), .q(stat_misses)
  );
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = ^{resp_hit, stat_clr, stat_done};
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_ifetch = '0;
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_trace_dispatcher.sv
// Scoreboard bench for trace_dispatcher: stimulus queues expected requests, a monitor checks handshakes.
module tb_trace_dispatcher;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int SAT     = (1 << CNT_W) - 1;
`ifdef DISPATCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              trace_valid, trace_ready;
  logic [3:0]        trace_cmd;
  logic [ADDR_W-1:0] trace_addr;
  logic              req_valid, req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid, resp_hit;
  logic              busy, cmd_err, timeout_err;
  logic [CNT_W-1:0]  stat_reads, stat_writes, stat_ifetch, stat_hits, stat_misses;

  trace_dispatcher #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cmd(trace_cmd), .trace_addr(trace_addr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .busy(busy), .cmd_err(cmd_err), .timeout_err(timeout_err),
    .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_ifetch(stat_ifetch),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  int   n_exp_hs = 0;
  int   m_reads = 0, m_writes = 0, m_ifetch = 0, m_hits = 0, m_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic int es(input int v);
    return STATS_EN ? v : 0;
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, " stat_reads"},  64'(stat_reads),  64'(es(m_reads)));
    chk({tag, " stat_writes"}, 64'(stat_writes), 64'(es(m_writes)));
    chk({tag, " stat_ifetch"}, 64'(stat_ifetch), 64'(es(m_ifetch)));
    chk({tag, " stat_hits"},   64'(stat_hits),   64'(es(m_hits)));
    chk({tag, " stat_misses"}, 64'(stat_misses), 64'(es(m_misses)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request monitor: sampled mid-cycle, sees the handshake the next edge will take.
  always @(negedge clk) begin
    if (reset_n && req_valid && req_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got op=%0d addr=0x%0h expected no request", req_op, req_addr);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("mon req_op", 64'(req_op), 64'(e.op));
        chk("mon req_addr", 64'(req_addr), 64'(e.addr));
      end
    end
  end

  task automatic push_exp(input logic [3:0] cmd, input logic [ADDR_W-1:0] addr);
    req_t e;
    e.op   = cmd;
    e.addr = (cmd == 4'd8 || cmd == 4'd9) ? '0 : addr;
    exp_q.push_back(e);
  endtask

  // Full record: accept, hold ISSUE rdy_wait cycles, respond after resp_wait WAIT_RESP cycles.
  task automatic run_op(input logic [3:0] cmd, input logic [ADDR_W-1:0] addr,
                        input int rdy_wait, input int resp_wait, input logic hit);
    logic [ADDR_W-1:0] ea;
    ea = (cmd == 4'd8 || cmd == 4'd9) ? '0 : addr;
    chk("pre trace_ready", 64'(trace_ready), 64'd1);
    trace_valid = 1'b1; trace_cmd = cmd; trace_addr = addr; req_ready = 1'b0;
    push_exp(cmd, addr);
    tick();
    trace_valid = 1'b0;
    if (cmd == 4'd8) begin
      m_reads = 0; m_writes = 0; m_ifetch = 0; m_hits = 0; m_misses = 0;
      chk_stats("after_clear");
    end
    chk("issue req_valid", 64'(req_valid), 64'd1);
    chk("issue req_op", 64'(req_op), 64'(cmd));
    chk("issue busy", 64'(busy), 64'd1);
    for (int i = 0; i < rdy_wait; i++) begin
      tick();
      chk("hold req_valid", 64'(req_valid), 64'd1);
      chk("hold req_addr", 64'(req_addr), 64'(ea));
    end
    req_ready = 1'b1;
    n_exp_hs++;
    tick();
    req_ready = 1'b0;
    chk("wait req_valid", 64'(req_valid), 64'd0);
    for (int i = 0; i < resp_wait; i++) tick();
    chk("wait trace_ready", 64'(trace_ready), 64'd0);
    resp_valid = 1'b1; resp_hit = hit;
    tick();
    resp_valid = 1'b0; resp_hit = 1'b0;
    case (cmd)
      4'd0: m_reads  = sat_inc(m_reads);
      4'd1: m_writes = sat_inc(m_writes);
      4'd2: m_ifetch = sat_inc(m_ifetch);
      default: ;
    endcase
    if (cmd <= 4'd2) begin
      if (hit) m_hits = sat_inc(m_hits);
      else     m_misses = sat_inc(m_misses);
    end
    chk("done trace_ready", 64'(trace_ready), 64'd1);
    chk("done busy", 64'(busy), 64'd0);
    chk_stats("done");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] ill [3];
    logic [3:0] other [5];
    ill   = '{4'd7, 4'd10, 4'd15};
    other = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd9};
    reset_n = 1'b0; trace_valid = 1'b0; trace_cmd = '0; trace_addr = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst trace_ready", 64'(trace_ready), 64'd1);
    chk("rst req_valid", 64'(req_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst cmd_err", 64'(cmd_err), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);
    chk_stats("rst");

    run_op(4'd0, 32'h0000_1000, 0, 1, 1'b1);
    run_op(4'd1, 32'hDEAD_BEE0, 5, 0, 1'b0);

    foreach (ill[i]) begin
      trace_valid = 1'b1; trace_cmd = ill[i]; trace_addr = 32'h5555_0000;
      tick();
      trace_valid = 1'b0;
      chk("illegal cmd_err", 64'(cmd_err), 64'd1);
      chk("illegal req_valid", 64'(req_valid), 64'd0);
      chk("illegal busy", 64'(busy), 64'd0);
      tick();
      chk("illegal still idle", 64'(req_valid), 64'd0);
    end

    run_op(4'd2, 32'h0000_2000, 0, 0, 1'b0);
    foreach (other[i]) run_op(other[i], 32'hABCD_0000 + 32'(i), 1, 1, 1'b1);

    run_op(4'd0, 32'h0000_0040, 0, 0, 1'b1);
    run_op(4'd0, 32'h0000_0080, 0, 0, 1'b0);
    run_op(4'd0, 32'h0000_00C0, 0, 0, 1'b1);
    run_op(4'd8, 32'hFFFF_FFFF, 0, 0, 1'b0);

    // Response on the expiry cycle wins over the watchdog.
    run_op(4'd0, 32'h0000_0100, 0, TIMEOUT - 1, 1'b1);
    chk("expiry timeout_err", 64'(timeout_err), 64'd0);

    trace_valid = 1'b1; trace_cmd = 4'd0; trace_addr = 32'h0000_3000;
    push_exp(4'd0, 32'h0000_3000);
    tick();
    trace_valid = 1'b0; req_ready = 1'b1; n_exp_hs++;
    tick();
    req_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("wd last busy", 64'(busy), 64'd1);
    chk("wd last timeout_err", 64'(timeout_err), 64'd0);
    tick();
    chk("wd timeout_err", 64'(timeout_err), 64'd1);
    chk("wd busy", 64'(busy), 64'd0);
    chk("wd trace_ready", 64'(trace_ready), 64'd1);
    resp_valid = 1'b1; resp_hit = 1'b1;
    tick();
    resp_valid = 1'b0; resp_hit = 1'b0;
    chk("late resp busy", 64'(busy), 64'd0);
    chk_stats("late_resp");

    trace_valid = 1'b1; trace_cmd = 4'd1; trace_addr = 32'h0000_4000;
    tick();
    trace_valid = 1'b0;
    chk("pre-rst req_valid", 64'(req_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async req_valid", 64'(req_valid), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    exp_q.delete();
    m_reads = 0; m_writes = 0; m_ifetch = 0; m_hits = 0; m_misses = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post-rst cmd_err", 64'(cmd_err), 64'd0);
    chk("post-rst timeout_err", 64'(timeout_err), 64'd0);
    chk("post-rst trace_ready", 64'(trace_ready), 64'd1);
    chk_stats("post_rst");

    run_op(4'd2, 32'h0000_5000, 2, 2, 1'b1);
    tick();
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    chk("handshake count", 64'(n_hs), 64'(n_exp_hs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
